meter_time_counter: RTL and testbench

Parking-meter time accumulator and BCD converter. Consumes single-cycle debounced button pulses, preset switches and a 1 Hz tick; maintains remaining time in seconds, saturating at 9999. Produces a registered BCD image of that count for the display FSM, plus a flash flag and an expired flag. Sits between the debouncers/clock divider and the display FSM, replacing the combinational divide/modulo path.

---
 rtl/meter_time_counter.sv | 148 ++++++++++++++
 tb/tb_meter_time_counter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/meter_time_counter.sv
// Parking-meter time accumulator with a sequential binary-to-BCD converter.
// Keeps remaining seconds (saturating at MAX_COUNT). Presents a registered BCD
// image of that count, a low-time flash flag and an expired flag.
module meter_time_counter #(
  parameter int MAX_COUNT   = 9999,
  parameter int FLASH_LIMIT = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        add10,
  input  logic        add180,
  input  logic        add200,
  input  logic        add550,
  input  logic        reset10,
  input  logic        reset205,
  input  logic        sec_tick,
  output logic [13:0] bcount,
  output logic [15:0] bcd,
  output logic        bcd_valid,
  output logic        flash,
  output logic        expired
);

  localparam logic [14:0] MAX_WIDE     = 15'(MAX_COUNT);
  localparam logic [13:0] MAX_NARROW   = 14'(MAX_COUNT);
  localparam logic [13:0] FLASH_THRESH = 14'(FLASH_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  conv_state_t state, state_next;

  logic [14:0] add_sum;
  logic [14:0] raw_sum;
  logic [13:0] sat_count;
  logic [13:0] count_next;

  logic [13:0] last;
  logic [13:0] bin_sr;
  logic [15:0] bcd_sr;
  logic [15:0] bcd_adj;
  logic [29:0] shifted;
  logic [3:0]  bit_cnt;

  // Add/tick path: accumulate pulses in 15 bits, saturate, then take the tick.
  always_comb begin
    add_sum = (add10  ? 15'd10  : 15'd0)
            + (add180 ? 15'd180 : 15'd0)
            + (add200 ? 15'd200 : 15'd0)
            + (add550 ? 15'd550 : 15'd0);
    raw_sum    = {1'b0, bcount} + add_sum;
    sat_count  = (raw_sum > MAX_WIDE) ? MAX_NARROW : raw_sum[13:0];
    count_next = sat_count;
    if (sec_tick && (sat_count != 14'd0)) begin
      count_next = sat_count - 14'd1;
    end
  end

  // Count register: reset, then presets (205 wins over 10), then add/tick.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments on every register so all flops sample
    // pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      bcount <= '0;
    end else if (reset205) begin
      bcount <= 14'd205;
    end else if (reset10) begin
      bcount <= 14'd10;
    end else begin
      bcount <= count_next;
    end
  end

  // Converter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Converter next-state: start on mismatch, 14 shifts, one cycle to publish.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    case (state)
      IDLE:    if (bcount != last) state_next = CONV;
      CONV:    if (bit_cnt == 4'd13) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Double-dabble step: add 3 to every digit >= 5, then shift one bit in.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, bin_sr} << 1;
  end

  // Converter datapath: snapshot, shift registers, bit counter, published BCD.
  always_ff @(posedge clk) begin
    // NOTE: the working shift registers are reloaded on every capture, so
    // their reset is not functionally required; it is kept so that a reset
    // leaves the whole block in one known, repeatable state.
    if (reset) begin
      last    <= '0;
      bcd     <= '0;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bcount != last) begin
            bin_sr  <= bcount;
            last    <= bcount;
            bcd_sr  <= '0;
            bit_cnt <= '0;
          end
        end
        CONV: begin
          bcd_sr  <= shifted[29:14];
          bin_sr  <= shifted[13:0];
          bit_cnt <= bit_cnt + 4'd1;
        end
        DONE: begin
          bcd <= bcd_sr;
        end
        default: begin
        end
      endcase
    end
  end

  assign bcd_valid = (state == IDLE) && (last == bcount);
  assign flash     = (bcount < FLASH_THRESH);
  assign expired   = (bcount == 14'd0);

endmodule

// File: tb/tb_meter_time_counter.sv
// Directed bench for meter_time_counter. Expected BCD images are queued when
// the stimulus that causes them is driven and popped when the converter
// reports valid (or at a fixed cycle for latency and stale-result checks).
module tb_meter_time_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        add10 = 1'b0;
  logic        add180 = 1'b0;
  logic        add200 = 1'b0;
  logic        add550 = 1'b0;
  logic        reset10 = 1'b0;
  logic        reset205 = 1'b0;
  logic        sec_tick = 1'b0;
  logic [13:0] bcount;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic        flash;
  logic        expired;

  int checks = 0;
  int errors = 0;
  logic [15:0] bcd_q[$];
  logic        any_valid;

  meter_time_counter dut (
    .clk       (clk),
    .reset     (reset),
    .add10     (add10),
    .add180    (add180),
    .add200    (add200),
    .add550    (add550),
    .reset10   (reset10),
    .reset205  (reset205),
    .sec_tick  (sec_tick),
    .bcount    (bcount),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .flash     (flash),
    .expired   (expired)
  );

  always #5 clk = ~clk;

  // Safety net against a hang anywhere in the sequence.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Advance one clock and sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of pulses, then drop them.
  task automatic drive(input logic a10, input logic a180, input logic a200,
                       input logic a550, input logic tk);
    add10 = a10; add180 = a180; add200 = a200; add550 = a550; sec_tick = tk;
    step();
    add10 = 1'b0; add180 = 1'b0; add200 = 1'b0; add550 = 1'b0; sec_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Compare bcd against the oldest queued expectation.
  task automatic pop_bcd(input string tag);
    logic [15:0] exp;
    if (bcd_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      exp = bcd_q.pop_front();
      check(tag, 32'(bcd), 32'(exp));
    end
  endtask

  // Wait (bounded) for the converter to settle, then check the image.
  task automatic expect_bcd(input string tag);
    int n = 0;
    while (bcd_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(bcd_valid), 32'd1);
    pop_bcd(tag);
  endtask

  initial begin
    // Reset state.
    step();
    step();
    check("rst_bcount", 32'(bcount), 32'd0);
    check("rst_bcd", 32'(bcd), 32'h0000);
    check("rst_valid", 32'(bcd_valid), 32'd1);
    check("rst_flash", 32'(flash), 32'd1);
    check("rst_expired", 32'(expired), 32'd1);
    reset = 1'b0;

    // add10: one-cycle count latency, BCD exactly 16 edges later.
    bcd_q.push_back(16'h0010);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("add10_bcount", 32'(bcount), 32'd10);
    check("add10_flash", 32'(flash), 32'd1);
    check("add10_expired", 32'(expired), 32'd0);
    check("add10_valid_low", 32'(bcd_valid), 32'd0);
    repeat (15) step();
    check("lat_e15_valid", 32'(bcd_valid), 32'd0);
    step();
    check("lat_e16_valid", 32'(bcd_valid), 32'd1);
    pop_bcd("lat_e16_bcd");

    // Simultaneous pulses accumulate.
    do_reset();
    bcd_q.push_back(16'h0930);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("multi_bcount", 32'(bcount), 32'd930);
    check("multi_flash", 32'(flash), 32'd0);
    expect_bcd("multi_bcd");

    // Saturation: 9990, then add550 with a tick, then add550 alone.
    do_reset();
    repeat (18) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (9) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("load_9990", 32'(bcount), 32'd9990);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("sat_tick_9998", 32'(bcount), 32'd9998);
    bcd_q.push_back(16'h9999);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("sat_9999", 32'(bcount), 32'd9999);
    expect_bcd("sat_bcd");

    // Preset 205 overrides add and tick; then count down past the flash edge.
    reset205 = 1'b1;
    add550 = 1'b1;
    sec_tick = 1'b1;
    step();
    add550 = 1'b0;
    check("preset205_add", 32'(bcount), 32'd205);
    step();
    check("preset205_hold", 32'(bcount), 32'd205);
    reset205 = 1'b0;
    repeat (5) step();
    check("tick5_bcount", 32'(bcount), 32'd200);
    check("tick5_flash", 32'(flash), 32'd0);
    step();
    sec_tick = 1'b0;
    check("tick6_bcount", 32'(bcount), 32'd199);
    check("tick6_flash", 32'(flash), 32'd1);
    bcd_q.push_back(16'h0199);
    expect_bcd("tick_bcd");

    // Preset 10, count down to 2, then 1, 0 and no underflow.
    reset10 = 1'b1;
    step();
    reset10 = 1'b0;
    check("preset10", 32'(bcount), 32'd10);
    repeat (8) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("down_2", 32'(bcount), 32'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("down_1", 32'(bcount), 32'd1);
    check("down_1_expired", 32'(expired), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("down_0", 32'(bcount), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("down_0_hold", 32'(bcount), 32'd0);
    check("down_0_expired", 32'(expired), 32'd1);
    bcd_q.push_back(16'h0000);
    expect_bcd("zero_bcd");

    // Change during a conversion: stale 0x0010 lands first, then 0x0020.
    bcd_q.push_back(16'h0010);
    bcd_q.push_back(16'h0020);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);       // E0: 10
    any_valid = bcd_valid;
    step();                                    // E1: capture of 10
    any_valid = any_valid | bcd_valid;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);       // E2: 20
    any_valid = any_valid | bcd_valid;
    check("stale_bcount", 32'(bcount), 32'd20);
    repeat (14) begin                          // E3..E16
      step();
      any_valid = any_valid | bcd_valid;
    end
    pop_bcd("stale_bcd");
    repeat (15) begin                          // E17..E31
      step();
      any_valid = any_valid | bcd_valid;
    end
    check("stale_valid_low", 32'(any_valid), 32'd0);
    step();                                    // E32
    check("restart_valid", 32'(bcd_valid), 32'd1);
    pop_bcd("restart_bcd");

    // Reset in the middle of converting 1234.
    do_reset();
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("load_1234", 32'(bcount), 32'd1234);
    repeat (5) step();
    check("mid_busy", 32'(bcd_valid), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_bcount", 32'(bcount), 32'd0);
    check("midrst_bcd", 32'(bcd), 32'h0000);
    check("midrst_valid", 32'(bcd_valid), 32'd1);
    check("midrst_expired", 32'(expired), 32'd1);
    repeat (16) step();
    check("midrst_bcd_later", 32'(bcd), 32'h0000);
    check("midrst_valid_later", 32'(bcd_valid), 32'd1);
    check("sb_drained", 32'(bcd_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
